// File: rtl/combination_pkg.sv
// Shared types and helpers for the combination histogram stage.
package combination_pkg;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ACCUM   = 2'd1,
    DRAIN   = 2'd2,
    READOUT = 2'd3
  } hist_state_t;

  // Saturating add on values up to 64 bits wide; w is the live result width (w < 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w, output logic sat);
    logic [64:0] sum;
    logic [64:0] max;
    max = (65'd1 << w) - 65'd1;
    sum = {1'b0, a} + {1'b0, b};
    sat = (sum > max);
    sat_add = sat ? max[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/hist_skid_fifo.sv
// Small output FIFO absorbing readout beats while m_tready is low; exposes free slots as credit.
module hist_skid_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] free
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop     = pop && (count_q != '0);
  assign do_push    = push && (count_q < CNT_W'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign free       = CNT_W'(DEPTH) - count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/combination_histogram.sv
// Block-RAM histogram with pipelined read-modify-write accumulation and read-and-clear readout.
module combination_histogram
  import combination_pkg::*;
#(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned WIDTH_CNT   = 4,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in_vd,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [WIDTH_CNT-1:0]   data_in_cnt,
  input  logic                   readout_start,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [COUNT_WIDTH-1:0] m_tdata,
  output logic [WIDTH-1:0]       m_tuser,
  output logic                   m_tlast,
  output logic                   busy,
  output logic [31:0]            dropped_cnt,
  output logic                   saturated
);

  localparam int unsigned RMW_LAT    = RD_LAT + 1;
  localparam int unsigned NBINS      = 2 ** WIDTH;
  localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
  localparam int unsigned FREE_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FIFO_DW    = WIDTH + 1 + COUNT_WIDTH;
  localparam int unsigned DRAIN_W    = $clog2(RMW_LAT + 1);
  localparam int unsigned TAIL       = RD_LAT - 1;
  localparam logic [WIDTH-1:0] LAST_ADDR = '1;

  hist_state_t        state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               ro_done_q, ro_done_d;
  logic               start_accept;

  logic [COUNT_WIDTH-1:0] mem [NBINS];
  logic [WIDTH-1:0]       rd_addr;
  logic [COUNT_WIDTH-1:0] ram_q [RD_LAT];
  logic [WIDTH-1:0]       pipe_addr_q [RD_LAT];
  logic [WIDTH_CNT-1:0]   pipe_cnt_q [RD_LAT];
  logic [RD_LAT-1:0]      rmw_vld_q, ro_vld_q;

  logic                   we;
  logic [WIDTH-1:0]       wa;
  logic [COUNT_WIDTH-1:0] wd;

  logic                   wb_vld_q;
  logic [WIDTH-1:0]       wb_addr_q;
  logic [COUNT_WIDTH-1:0] wb_data_q;

  logic [63:0]            sum_full;
  logic [COUNT_WIDTH-1:0] sum_val;
  logic                   sum_sat;
  logic                   unused_sum_hi;

  logic                   accept_evt, ro_issue;
  logic [FREE_W-1:0]      inflight, fifo_free;
  logic                   fifo_push, fifo_pop;
  logic [FIFO_DW-1:0]     fifo_push_data, fifo_head;

  logic [31:0]            dropped_q;
  logic                   saturated_q;

  assign accept_evt = (state_q == ACCUM) && data_in_vd && (data_in_cnt != '0);
  assign rd_addr    = (state_q == READOUT) ? addr_q : data_in;

  // Readout reads only when a FIFO slot is guaranteed, counting reads still in the RAM pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + FREE_W'(ro_vld_q[i]);
  end
  assign ro_issue = (state_q == READOUT) && !ro_done_q && (inflight < fifo_free);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    ro_done_d    = ro_done_q;
    start_accept = 1'b0;
    unique case (state_q)
      CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) state_d = ACCUM;
      end
      ACCUM: begin
        if (readout_start) begin
          start_accept = 1'b1;
          state_d      = DRAIN;
          drain_d      = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_W'(RMW_LAT - 1)) begin
          state_d   = READOUT;
          addr_d    = '0;
          ro_done_d = 1'b0;
        end
      end
      READOUT: begin
        if (ro_issue) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) ro_done_d = 1'b1;
        end
        if (m_tvalid && m_tready && m_tlast) state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      addr_q    <= '0;
      drain_q   <= '0;
      ro_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      ro_done_q <= ro_done_d;
    end
  end

  // RAM read port with RD_LAT-deep registered output; address/count ride alongside.
  always_ff @(posedge clk) begin
    ram_q[0]       <= mem[rd_addr];
    pipe_addr_q[0] <= rd_addr;
    pipe_cnt_q[0]  <= data_in_cnt;
    for (int i = 1; i < RD_LAT; i++) begin
      ram_q[i]       <= ram_q[i-1];
      pipe_addr_q[i] <= pipe_addr_q[i-1];
      pipe_cnt_q[i]  <= pipe_cnt_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmw_vld_q <= '0;
      ro_vld_q  <= '0;
    end else begin
      rmw_vld_q[0] <= accept_evt;
      ro_vld_q[0]  <= ro_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        rmw_vld_q[i] <= rmw_vld_q[i-1];
        ro_vld_q[i]  <= ro_vld_q[i-1];
      end
    end
  end

  always_comb begin
    sum_sat  = 1'b0;
    sum_full = sat_add(64'(ram_q[TAIL]), 64'(pipe_cnt_q[TAIL]), COUNT_WIDTH, sum_sat);
  end
  assign sum_val       = sum_full[COUNT_WIDTH-1:0];
  assign unused_sum_hi = ^sum_full[63:COUNT_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_vld_q  <= rmw_vld_q[TAIL];
      wb_addr_q <= pipe_addr_q[TAIL];
      wb_data_q <= sum_val;
    end
  end

  // Write port: clear sweep, read-and-clear during readout, otherwise RMW write-back.
  always_comb begin
    we = wb_vld_q;
    wa = wb_addr_q;
    wd = wb_data_q;
    unique case (state_q)
      CLEAR: begin
        we = 1'b1;
        wa = addr_q;
        wd = '0;
      end
      READOUT: begin
        we = ro_issue;
        wa = addr_q;
        wd = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign fifo_push      = ro_vld_q[TAIL];
  assign fifo_push_data = {pipe_addr_q[TAIL], pipe_addr_q[TAIL] == LAST_ADDR, ram_q[TAIL]};
  assign fifo_pop       = m_tvalid && m_tready;

  hist_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (FIFO_DW),
    .CNT_W (FREE_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (fifo_push_data),
    .pop        (fifo_pop),
    .head_valid (m_tvalid),
    .head_data  (fifo_head),
    .free       (fifo_free)
  );

  assign {m_tuser, m_tlast, m_tdata} = fifo_head;

  // A clip in flight while readout_start is taken stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q   <= '0;
      saturated_q <= 1'b0;
    end else begin
      if (data_in_vd && (state_q != ACCUM) && (dropped_q != '1)) dropped_q <= dropped_q + 1'b1;
      if (rmw_vld_q[TAIL] && sum_sat) saturated_q <= 1'b1;
      else if (start_accept)          saturated_q <= 1'b0;
    end
  end

  assign dropped_cnt = dropped_q;
  assign saturated   = saturated_q;
  assign busy        = (state_q != ACCUM);

endmodule
